// File: rtl/mem_access_sequencer_if.sv
// Bus bundle between the relay-memory access sequencer, its two requesters
// (CPU control path and preloader) and the memory array.
interface mem_access_sequencer_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ld_req;
  logic [14:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ack;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic        busy;
  logic        load_active;

  // The sequencer side; requesters and the memory model take the master view.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_req, ld_addr, ld_data, mem_rdata,
    output cpu_ack, cpu_rdata, ld_ack, mem_addr, mem_wdata, mem_read, mem_write,
           busy, load_active
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_req, ld_addr, ld_data, mem_rdata,
    input  cpu_ack, cpu_rdata, ld_ack, mem_addr, mem_wdata, mem_read, mem_write,
           busy, load_active
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Arbitrates CPU and preloader accesses to the relay memory and stretches each
// access into setup / strobe / hold phases with strobes only on a stable bus.
module mem_access_sequencer #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input logic                   clk,
  input logic                   reset,
  mem_access_sequencer_if.slave bus
);

  generate
    if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
        HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_param
      $error("mem_access_sequencer: phase lengths must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] phase_cnt;
  logic       is_write;

  // The relay memory is 32 KB, so the top CPU address bit has no meaning here.
  logic unused_addr_msb;
  assign unused_addr_msb = bus.cpu_addr[15];

  // Counter holds remaining cycles minus one; each phase ends when it reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      phase_cnt       <= '0;
      is_write        <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.cpu_ack     <= 1'b0;
      bus.ld_ack      <= 1'b0;
      bus.cpu_rdata   <= '0;
      bus.busy        <= 1'b0;
      bus.load_active <= 1'b0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.ld_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ld_req) begin
            bus.mem_addr    <= bus.ld_addr;
            bus.mem_wdata   <= bus.ld_data;
            is_write        <= 1'b1;
            bus.load_active <= 1'b1;
            bus.busy        <= 1'b1;
            phase_cnt       <= SETUP_LOAD;
            state           <= SETUP;
          end else if (bus.cpu_req) begin
            bus.mem_addr    <= bus.cpu_addr[14:0];
            bus.mem_wdata   <= bus.cpu_wdata;
            is_write        <= bus.cpu_we;
            bus.load_active <= 1'b0;
            bus.busy        <= 1'b1;
            phase_cnt       <= SETUP_LOAD;
            state           <= SETUP;
          end
        end
        SETUP: begin
          if (phase_cnt == 4'd0) begin
            bus.mem_read  <= ~is_write;
            bus.mem_write <= is_write;
            phase_cnt     <= STROBE_LOAD;
            state         <= STROBE;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        STROBE: begin
          if (phase_cnt == 4'd0) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            // The loader only writes, so any read here belongs to the CPU.
            if (!is_write) begin
              bus.cpu_rdata <= bus.mem_rdata;
            end
            phase_cnt <= HOLD_LOAD;
            state     <= HOLD;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (phase_cnt == 4'd0) begin
            if (bus.load_active) begin
              bus.ld_ack <= 1'b1;
            end else begin
              bus.cpu_ack <= 1'b1;
            end
            state <= DONE;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        DONE: begin
          bus.busy        <= 1'b0;
          bus.load_active <= 1'b0;
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed and randomized checks of the access sequencer against a cycle-offset
// model of one access: setup, strobe, hold, then a single ack cycle.
module tb_mem_access_sequencer;

  localparam int S  = 1;
  localparam int T  = 2;
  localparam int H  = 1;
  localparam int L  = S + T + H;
  localparam int S2 = 3;
  localparam int T2 = 4;
  localparam int H2 = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_sequencer_if busA ();
  mem_access_sequencer_if busB ();

  mem_access_sequencer #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dutA (
    .clk  (clk),
    .reset(reset),
    .bus  (busA)
  );

  mem_access_sequencer #(.SETUP_CYC(S2), .STROBE_CYC(T2), .HOLD_CYC(H2)) dutB (
    .clk  (clk),
    .reset(reset),
    .bus  (busB)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0]  modelRdata;
  logic [14:0] lastAddr;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit isLd, input bit we, input logic [15:0] addr,
                               input logic [7:0] wdata, input logic [7:0] rdata);
    if (isLd) begin
      busA.ld_req  = 1'b1;
      busA.ld_addr = addr[14:0];
      busA.ld_data = wdata;
    end else begin
      busA.cpu_req   = 1'b1;
      busA.cpu_we    = we;
      busA.cpu_addr  = addr;
      busA.cpu_wdata = wdata;
    end
    busA.mem_rdata = rdata;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mem_addr"}, 32'(busA.mem_addr), 0);
    checkOutput({tag, "_mem_wdata"}, 32'(busA.mem_wdata), 0);
    checkOutput({tag, "_cpu_rdata"}, 32'(busA.cpu_rdata), 0);
    checkOutput({tag, "_mem_read"}, 32'(busA.mem_read), 0);
    checkOutput({tag, "_mem_write"}, 32'(busA.mem_write), 0);
    checkOutput({tag, "_cpu_ack"}, 32'(busA.cpu_ack), 0);
    checkOutput({tag, "_ld_ack"}, 32'(busA.ld_ack), 0);
    checkOutput({tag, "_busy"}, 32'(busA.busy), 0);
    checkOutput({tag, "_load_active"}, 32'(busA.load_active), 0);
  endtask

  // Called in the IDLE cycle whose closing edge grants; returns in the ack cycle.
  task automatic runTxn(input bit isLd, input bit we, input logic [15:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rdata);
    bit wr;
    bit inStrobe;
    bit done;
    logic [7:0] expRdata;
    wr = isLd | we;
    applyStimulus(isLd, we, addr, wdata, rdata);
    for (int k = 1; k <= L + 1; k++) begin
      tick();
      inStrobe = (k > S) && (k <= S + T);
      done     = (k == L + 1);
      expRdata = (!wr && k > S + T) ? rdata : modelRdata;
      checkOutput("busy", 32'(busA.busy), 1);
      checkOutput("load_active", 32'(busA.load_active), 32'(isLd));
      checkOutput("mem_addr", 32'(busA.mem_addr), 32'(addr[14:0]));
      if (wr) checkOutput("mem_wdata", 32'(busA.mem_wdata), 32'(wdata));
      checkOutput("mem_read", 32'(busA.mem_read), 32'(!wr && inStrobe));
      checkOutput("mem_write", 32'(busA.mem_write), 32'(wr && inStrobe));
      checkOutput("cpu_ack", 32'(busA.cpu_ack), 32'(!isLd && done));
      checkOutput("ld_ack", 32'(busA.ld_ack), 32'(isLd && done));
      checkOutput("cpu_rdata", 32'(busA.cpu_rdata), 32'(expRdata));
    end
    if (!wr) modelRdata = rdata;
    lastAddr = addr[14:0];
  endtask

  task automatic idleCheck;
    tick();
    checkOutput("idle_busy", 32'(busA.busy), 0);
    checkOutput("idle_load_active", 32'(busA.load_active), 0);
    checkOutput("idle_strobes", 32'({busA.mem_read, busA.mem_write}), 0);
    checkOutput("idle_acks", 32'({busA.cpu_ack, busA.ld_ack}), 0);
    checkOutput("idle_mem_addr", 32'(busA.mem_addr), 32'(lastAddr));
    checkOutput("idle_cpu_rdata", 32'(busA.cpu_rdata), 32'(modelRdata));
  endtask

  initial begin
    bit isLd;
    bit we;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    busA.cpu_req = 0; busA.cpu_we = 0; busA.cpu_addr = '0; busA.cpu_wdata = '0;
    busA.ld_req = 0; busA.ld_addr = '0; busA.ld_data = '0; busA.mem_rdata = '0;
    busB.cpu_req = 0; busB.cpu_we = 0; busB.cpu_addr = '0; busB.cpu_wdata = '0;
    busB.ld_req = 0; busB.ld_addr = '0; busB.ld_data = '0; busB.mem_rdata = '0;
    modelRdata = '0;
    lastAddr   = '0;

    // Reset with both requests pending; loader must win right after reset.
    reset = 1'b1;
    applyStimulus(0, 0, 16'h0055, 8'h00, 8'h00);
    applyStimulus(1, 1, 16'h0042, 8'h99, 8'h00);
    tick();
    checkResetValues("rst1");
    tick();
    checkResetValues("rst2");
    reset = 1'b0;
    runTxn(1, 1, 16'h0042, 8'h99, 8'h00);
    busA.ld_req = 1'b0;
    idleCheck();
    runTxn(0, 0, 16'h0055, 8'h00, 8'h3C);
    busA.cpu_req = 1'b0;
    idleCheck();

    // CPU read with the ignored top address bit set, then a CPU write.
    runTxn(0, 0, 16'h8123, 8'h00, 8'h5A);
    busA.cpu_req = 1'b0;
    idleCheck();
    runTxn(0, 1, 16'h0010, 8'hC3, 8'hEE);
    busA.cpu_req = 1'b0;
    idleCheck();

    // Simultaneous requests: loader first, CPU read granted in the following IDLE.
    applyStimulus(0, 0, 16'h0200, 8'h00, 8'h6B);
    runTxn(1, 1, 16'h0007, 8'h11, 8'h6B);
    busA.ld_req = 1'b0;
    idleCheck();
    runTxn(0, 0, 16'h0200, 8'h00, 8'h6B);
    busA.cpu_req = 1'b0;
    idleCheck();

    // Loader burst with the request held high across all four writes.
    for (int i = 0; i < 4; i++) begin
      runTxn(1, 1, 16'(i), 8'hA0 + 8'(i), 8'($urandom));
      if (i == 3) busA.ld_req = 1'b0;
      idleCheck();
    end

    // Randomized accesses separated by random idle gaps.
    for (int n = 0; n < 16; n++) begin
      isLd  = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = 16'($urandom);
      wdata = 8'($urandom);
      rdata = 8'($urandom);
      runTxn(isLd, we, addr, wdata, rdata);
      busA.cpu_req = 1'b0;
      busA.ld_req  = 1'b0;
      idleCheck();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idleCheck();
    end

    // Reset during the second strobe cycle of a CPU write drops the access.
    applyStimulus(0, 1, 16'h0ABC, 8'h5D, 8'h00);
    tick();
    checkOutput("mid_k1_mem_write", 32'(busA.mem_write), 0);
    tick();
    checkOutput("mid_k2_mem_write", 32'(busA.mem_write), 1);
    tick();
    checkOutput("mid_k3_mem_write", 32'(busA.mem_write), 1);
    reset = 1'b1;
    tick();
    checkResetValues("midrst");
    reset = 1'b0;
    modelRdata = '0;
    lastAddr   = '0;
    runTxn(0, 1, 16'h0ABC, 8'h5D, 8'h00);
    busA.cpu_req = 1'b0;
    idleCheck();

    // Longer phases on the second instance.
    busB.cpu_we    = 1'b0;
    busB.cpu_addr  = 16'h0333;
    busB.mem_rdata = 8'hD4;
    busB.cpu_req   = 1'b1;
    for (int k = 1; k <= S2 + T2 + H2 + 1; k++) begin
      tick();
      checkOutput("b_mem_read", 32'(busB.mem_read), 32'(k > S2 && k <= S2 + T2));
      checkOutput("b_mem_write", 32'(busB.mem_write), 0);
      checkOutput("b_cpu_ack", 32'(busB.cpu_ack), 32'(k == S2 + T2 + H2 + 1));
      checkOutput("b_busy", 32'(busB.busy), 1);
    end
    checkOutput("b_cpu_rdata", 32'(busB.cpu_rdata), 32'h00D4);
    busB.cpu_req = 1'b0;
    tick();
    checkOutput("b_idle_busy", 32'(busB.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
